// File: rtl/sdes_pkg.sv
// Shared S-DES tables, key schedule and permutation helpers for the CBC/ECB decryptor.
// Chaining is selected in the top by the SDES_CBC_EN macro; this package is mode-independent.
package sdes_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_R1   = 2'd1,
        ST_R2   = 2'd2,
        ST_OUT  = 2'd3
    } state_e;

    typedef struct packed {
        logic [7:0] k1;
        logic [7:0] k2;
    } subkeys_t;

    // Tables list 1-based source positions, position 1 being the MSB.
    localparam int P10_T [10] = '{3, 5, 2, 7, 4, 10, 1, 9, 8, 6};
    localparam int P8_T  [8]  = '{6, 3, 7, 4, 8, 5, 10, 9};
    localparam int IP_T  [8]  = '{2, 6, 3, 1, 4, 8, 5, 7};
    localparam int IPI_T [8]  = '{4, 1, 3, 5, 7, 2, 8, 6};
    localparam int EP_T  [8]  = '{4, 1, 2, 3, 2, 3, 4, 1};
    localparam int P4_T  [4]  = '{2, 4, 3, 1};

    // S-boxes indexed by {row, col}, row = outer input bits, col = inner bits.
    localparam logic [1:0] S0_T [16] = '{
        2'd1, 2'd0, 2'd3, 2'd2,
        2'd3, 2'd2, 2'd1, 2'd0,
        2'd0, 2'd2, 2'd1, 2'd3,
        2'd3, 2'd1, 2'd3, 2'd2
    };
    localparam logic [1:0] S1_T [16] = '{
        2'd0, 2'd1, 2'd2, 2'd3,
        2'd2, 2'd0, 2'd1, 2'd3,
        2'd3, 2'd0, 2'd1, 2'd0,
        2'd2, 2'd1, 2'd0, 2'd3
    };

    function automatic logic [9:0] p10(input logic [9:0] k);
        logic [9:0] r;
        r = '0;
        for (int i = 0; i < 10; i++) r[4'(9 - i)] = k[4'(10 - P10_T[i])];
        return r;
    endfunction

    function automatic logic [7:0] p8(input logic [9:0] k);
        logic [7:0] r;
        r = '0;
        for (int i = 0; i < 8; i++) r[3'(7 - i)] = k[4'(10 - P8_T[i])];
        return r;
    endfunction

    function automatic logic [7:0] ip(input logic [7:0] x);
        logic [7:0] r;
        r = '0;
        for (int i = 0; i < 8; i++) r[3'(7 - i)] = x[3'(8 - IP_T[i])];
        return r;
    endfunction

    function automatic logic [7:0] ip_inv(input logic [7:0] x);
        logic [7:0] r;
        r = '0;
        for (int i = 0; i < 8; i++) r[3'(7 - i)] = x[3'(8 - IPI_T[i])];
        return r;
    endfunction

    function automatic logic [7:0] ep(input logic [3:0] x);
        logic [7:0] r;
        r = '0;
        for (int i = 0; i < 8; i++) r[3'(7 - i)] = x[2'(4 - EP_T[i])];
        return r;
    endfunction

    function automatic logic [3:0] p4(input logic [3:0] x);
        logic [3:0] r;
        r = '0;
        for (int i = 0; i < 4; i++) r[2'(3 - i)] = x[2'(4 - P4_T[i])];
        return r;
    endfunction

    function automatic logic [1:0] sbox(input logic [3:0] x, input logic sel_s1);
        logic [3:0] idx;
        idx = {x[3], x[0], x[2], x[1]};
        return sel_s1 ? S1_T[idx] : S0_T[idx];
    endfunction

    function automatic subkeys_t key_sched(input logic [9:0] key);
        logic [9:0] p;
        logic [4:0] l, r;
        subkeys_t   s;
        p    = p10(key);
        l    = {p[8:5], p[9]};
        r    = {p[3:0], p[4]};
        s.k1 = p8({l, r});
        l    = {l[2:0], l[4:3]};
        r    = {r[2:0], r[4:3]};
        s.k2 = p8({l, r});
        return s;
    endfunction

endpackage

// File: rtl/sdes_fk.sv
// S-DES round function fK: left nibble XORed with F(right, subkey), right nibble passed through.
// Purely combinational; one instance is time-shared by both decryption rounds.
module sdes_fk
    import sdes_pkg::*;
(
    input  logic [7:0] i_blk,
    input  logic [7:0] i_sk,
    output logic [7:0] o_blk
);

    logic [7:0] mix;
    logic [3:0] f_out;

    always_comb begin
        mix   = ep(i_blk[3:0]) ^ i_sk;
        f_out = p4({sbox(mix[7:4], 1'b0), sbox(mix[3:0], 1'b1)});
        o_blk = {i_blk[7:4] ^ f_out, i_blk[3:0]};
    end

endmodule

// File: rtl/sdes_cbc_dec.sv
// S-DES byte decryptor: IDLE -> R1 (fK K2, SW) -> R2 (fK K1, IP^-1, chain) -> OUT.
// Define SDES_CBC_EN for CBC chaining; without it the block is plain ECB.
module sdes_cbc_dec
    import sdes_pkg::*;
(
    input  logic       clk,
    input  logic       rstn,
    input  logic [9:0] i_key,
    input  logic [7:0] i_iv,
    input  logic       i_iv_load,
    input  logic       s_valid,
    output logic       s_ready,
    input  logic [7:0] s_data,
    output logic       m_valid,
    input  logic       m_ready,
    output logic [7:0] m_data
);

    state_e     state_q, state_d;
    logic [9:0] key_q, key_d;
    logic [7:0] blk_q, blk_d;
    logic [7:0] m_data_q, m_data_d;
    logic [7:0] chain_val;
    subkeys_t   sk;
    logic [7:0] fk_sk;
    logic [7:0] fk_out;

    // Subkeys come from the latched key, so i_key may move freely while a byte is in flight.
    assign sk    = key_sched(key_q);
    assign fk_sk = (state_q == ST_R1) ? sk.k2 : sk.k1;

    sdes_fk u_fk (
        .i_blk (blk_q),
        .i_sk  (fk_sk),
        .o_blk (fk_out)
    );

`ifdef SDES_CBC_EN
    logic [7:0] chain_q, chain_d;
    logic [7:0] cipher_q, cipher_d;

    // IV load lands on the accept edge, so R2 already sees it for the same byte.
    always_comb begin
        chain_d  = chain_q;
        cipher_d = cipher_q;
        if (state_q == ST_IDLE) begin
            if (i_iv_load) chain_d = i_iv;
            if (s_valid)   cipher_d = s_data;
        end else if (state_q == ST_OUT && m_ready) begin
            chain_d = cipher_q;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            chain_q  <= 8'h00;
            cipher_q <= 8'h00;
        end else begin
            chain_q  <= chain_d;
            cipher_q <= cipher_d;
        end
    end

    assign chain_val = chain_q;
`else
    logic unused_iv;
    assign unused_iv = ^{i_iv, i_iv_load};
    assign chain_val = 8'h00;
`endif

    always_comb begin
        state_d  = state_q;
        key_d    = key_q;
        blk_d    = blk_q;
        m_data_d = m_data_q;
        case (state_q)
            ST_IDLE: begin
                if (s_valid) begin
                    state_d = ST_R1;
                    key_d   = i_key;
                    blk_d   = ip(s_data);
                end
            end
            ST_R1: begin
                state_d = ST_R2;
                blk_d   = {fk_out[3:0], fk_out[7:4]};
            end
            ST_R2: begin
                state_d  = ST_OUT;
                m_data_d = ip_inv(fk_out) ^ chain_val;
            end
            ST_OUT: begin
                if (m_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= ST_IDLE;
            key_q    <= 10'h000;
            blk_q    <= 8'h00;
            m_data_q <= 8'h00;
        end else begin
            state_q  <= state_d;
            key_q    <= key_d;
            blk_q    <= blk_d;
            m_data_q <= m_data_d;
        end
    end

    assign s_ready = (state_q == ST_IDLE);
    assign m_valid = (state_q == ST_OUT);
    assign m_data  = m_data_q;

endmodule

// File: tb/tb_sdes_cbc_dec.sv
// Self-checking bench for sdes_cbc_dec: vector table plus hand sequences for backpressure,
// in-flight key change and reset in R2. Expected bytes come from an S-DES encryption model.
`timescale 1ns/1ps
module tb_sdes_cbc_dec;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic [9:0] i_key = '0;
  logic [7:0] i_iv = '0;
  logic       i_iv_load = 1'b0;
  logic       s_valid = 1'b0;
  logic       s_ready;
  logic [7:0] s_data = '0;
  logic       m_valid;
  logic       m_ready = 1'b1;
  logic [7:0] m_data;

  always #5 clk = ~clk;

  sdes_cbc_dec dut (
    .clk       (clk),
    .rstn      (rstn),
    .i_key     (i_key),
    .i_iv      (i_iv),
    .i_iv_load (i_iv_load),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_data    (s_data),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data)
  );

  typedef struct packed {
    logic [9:0] key;
    logic [7:0] ct;
    logic       ivl;
    logic [7:0] iv;
    logic [7:0] expv;
  } vec_t;

  localparam logic [9:0] KAT_KEY = 10'b1010000010;
  localparam int NV = 10;

  int         tests = 0;
  int         failed = 0;
  logic [7:0] exp_q[$];
  logic [7:0] chain_m = 8'h00;
  vec_t       vecs[NV];

  int S0[4][4] = '{'{1,0,3,2}, '{3,2,1,0}, '{0,2,1,3}, '{3,1,3,2}};
  int S1[4][4] = '{'{0,1,2,3}, '{2,0,1,3}, '{3,0,1,0}, '{2,1,0,3}};

  // tbl holds nout hex digits (1-based source positions) in its low bits, leftmost digit first.
  function automatic logic [9:0] tperm(input logic [9:0] x, input int nin,
                                       input logic [39:0] tbl, input int nout);
    logic [9:0] r;
    int pos;
    r = '0;
    for (int i = 0; i < nout; i++) begin
      pos = int'(tbl[6'(4*(nout-1-i)) +: 4]);
      r[4'(nout-1-i)] = x[4'(nin-pos)];
    end
    return r;
  endfunction

  function automatic logic [15:0] sched(input logic [9:0] key);
    logic [9:0] p, t;
    logic [4:0] l, r;
    logic [7:0] k1;
    p  = tperm(key, 10, 40'h35274A1986, 10);
    l  = {p[8:5], p[9]};
    r  = {p[3:0], p[4]};
    t  = tperm({l, r}, 10, 40'h00637485A9, 8);
    k1 = t[7:0];
    l  = {l[2:0], l[4:3]};
    r  = {r[2:0], r[4:3]};
    t  = tperm({l, r}, 10, 40'h00637485A9, 8);
    return {k1, t[7:0]};
  endfunction

  function automatic logic [3:0] fmix(input logic [3:0] r, input logic [7:0] k);
    logic [9:0] t;
    logic [7:0] e;
    logic [1:0] a, b;
    t = tperm({6'd0, r}, 4, 40'h0041232341, 8);
    e = t[7:0] ^ k;
    a = 2'(S0[{e[7], e[4]}][{e[6], e[5]}]);
    b = 2'(S1[{e[3], e[0]}][{e[2], e[1]}]);
    t = tperm({6'd0, a, b}, 4, 40'h0000002431, 4);
    return t[3:0];
  endfunction

  function automatic logic [7:0] enc(input logic [9:0] key, input logic [7:0] p);
    logic [15:0] ks;
    logic [9:0]  t;
    logic [7:0]  x;
    ks = sched(key);
    t  = tperm({2'd0, p}, 8, 40'h0026314857, 8);
    x  = t[7:0];
    x  = {x[7:4] ^ fmix(x[3:0], ks[15:8]), x[3:0]};
    x  = {x[3:0], x[7:4]};
    x  = {x[7:4] ^ fmix(x[3:0], ks[7:0]), x[3:0]};
    t  = tperm({2'd0, x}, 8, 40'h0041357286, 8);
    return t[7:0];
  endfunction

  // Expected output for plaintext pt whose ciphertext is ct; advances the chain model.
  function automatic logic [7:0] expect_pt(input logic [7:0] pt, input logic [7:0] ct,
                                           input logic ivl, input logic [7:0] iv);
    logic [7:0] r;
`ifdef SDES_CBC_EN
    if (ivl) chain_m = iv;
    r = pt ^ chain_m;
    chain_m = ct;
`else
    r = pt ^ 8'h00 ^ (ct & 8'h00) ^ ({8{ivl}} & iv & 8'h00);
`endif
    return r;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", nm, act, req);
    end
  endtask

  // Accepts one byte and returns at the first sample where m_valid is high (state OUT).
  task automatic run_byte(input vec_t v, input logic [9:0] key_flight, input string nm);
    int n;
    n = 0;
    while (!s_ready && n < 10) begin
      @(posedge clk); #1; n++;
    end
    check({nm, " s_ready"}, 32'(s_ready), 1);
    s_valid = 1'b1; s_data = v.ct; i_key = v.key; i_iv_load = v.ivl; i_iv = v.iv;
    exp_q.push_back(v.expv);
    @(posedge clk); #1;
    s_valid = 1'b0; s_data = 8'($urandom); i_key = key_flight;
    i_iv_load = 1'b1; i_iv = 8'($urandom);
    n = 1;
    while (!m_valid && n < 8) begin
      @(posedge clk); #1; n++;
    end
    check({nm, " latency"}, 32'(n), 3);
    if (exp_q.size() > 0) check({nm, " data"}, 32'(m_data), 32'(exp_q.pop_front()));
    i_iv_load = 1'b0;
  endtask

  task automatic release_byte(input string nm);
    m_ready = 1'b1;
    @(posedge clk); #1;
    check({nm, " done m_valid"}, 32'(m_valid), 0);
    check({nm, " done s_ready"}, 32'(s_ready), 1);
  endtask

  initial begin
    vec_t v;
    logic [7:0] pt;

    // Table: KAT rows first (chain starts at 0 after reset), then random keys/bytes.
    vecs[0] = '{key: KAT_KEY, ct: 8'h38, ivl: 1'b0, iv: 8'h00, expv: 8'h97};
    vecs[1] = '{key: KAT_KEY, ct: 8'h38, ivl: 1'b1, iv: 8'hFF, expv: 8'h00};
    vecs[2] = '{key: KAT_KEY, ct: 8'h38, ivl: 1'b0, iv: 8'h5A, expv: 8'h00};
`ifdef SDES_CBC_EN
    vecs[1].expv = 8'h68;
    vecs[2].expv = 8'hAF;
`else
    vecs[1].expv = 8'h97;
    vecs[2].expv = 8'h97;
`endif
    for (int i = 0; i < 3; i++)
      void'(expect_pt(8'h97, vecs[i].ct, vecs[i].ivl, vecs[i].iv));
    for (int i = 3; i < NV; i++) begin
      pt           = 8'($urandom);
      vecs[i].key  = 10'($urandom);
      vecs[i].ct   = enc(vecs[i].key, pt);
      vecs[i].ivl  = 1'($urandom_range(0, 1));
      vecs[i].iv   = 8'($urandom);
      vecs[i].expv = expect_pt(pt, vecs[i].ct, vecs[i].ivl, vecs[i].iv);
    end

    #1;
    check("reset m_valid", 32'(m_valid), 0);
    check("reset m_data", 32'(m_data), 0);
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    check("post-reset s_ready", 32'(s_ready), 1);
    check("post-reset m_valid", 32'(m_valid), 0);

    // Idle with s_valid low and wiggling data must not leave IDLE.
    for (int i = 0; i < 3; i++) begin
      s_data = 8'($urandom);
      @(posedge clk); #1;
      check("idle s_ready", 32'(s_ready), 1);
      check("idle m_valid", 32'(m_valid), 0);
    end

    for (int i = 0; i < NV; i++) begin
      run_byte(vecs[i], 10'($urandom), $sformatf("vec%0d", i));
      release_byte($sformatf("vec%0d", i));
    end

    // Backpressure: hold OUT for 5 cycles.
    v = '{key: KAT_KEY, ct: 8'h38, ivl: 1'b1, iv: 8'h00, expv: 8'h97};
    void'(expect_pt(8'h97, v.ct, v.ivl, v.iv));
    m_ready = 1'b0;
    run_byte(v, 10'($urandom), "bp");
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("bp hold m_valid", 32'(m_valid), 1);
      check("bp hold m_data", 32'(m_data), 32'h97);
      check("bp hold s_ready", 32'(s_ready), 0);
    end
    release_byte("bp");

    // Key changed to 3FF while in flight; the next byte really uses 3FF.
    v = '{key: KAT_KEY, ct: 8'h38, ivl: 1'b1, iv: 8'h00, expv: 8'h97};
    void'(expect_pt(8'h97, v.ct, v.ivl, v.iv));
    run_byte(v, 10'h3FF, "keychg");
    release_byte("keychg");
    pt = 8'($urandom);
    v.key = 10'h3FF; v.ct = enc(10'h3FF, pt); v.ivl = 1'b0; v.iv = 8'h00;
    v.expv = expect_pt(pt, v.ct, v.ivl, v.iv);
    run_byte(v, 10'($urandom), "key3ff");
    release_byte("key3ff");

    // Reset while in R2: nothing comes out, chain returns to 0.
    check("rst pre s_ready", 32'(s_ready), 1);
    s_valid = 1'b1; s_data = 8'h38; i_key = KAT_KEY;
    @(posedge clk); #1;
    s_valid = 1'b0;
    @(posedge clk); #1;
    rstn = 1'b0;
    #1;
    check("rst m_valid", 32'(m_valid), 0);
    check("rst m_data", 32'(m_data), 0);
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    chain_m = 8'h00;
    for (int i = 0; i < 4; i++) begin
      check("rst after m_valid", 32'(m_valid), 0);
      @(posedge clk); #1;
    end
    v = '{key: KAT_KEY, ct: 8'h38, ivl: 1'b0, iv: 8'hFF, expv: 8'h97};
    void'(expect_pt(8'h97, v.ct, v.ivl, v.iv));
    run_byte(v, 10'($urandom), "rst kat");
    release_byte("rst kat");

    check("scoreboard empty", 32'(exp_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
